code: RTL and testbench

//  Unsigned W x W array multiplier with registered product and valid tracking.

---
 rtl/code.sv | 140 ++++++++++++++
 tb/tb_code.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/code.sv
// Unsigned W x W Braun array multiplier with a registered product and valid tracking.
// Partial products a[j] & b[i] are summed row by row with W-bit ripple adders;
// the final carry-out of the last row becomes the product MSB.
// Optional feature macro: PIPE_STAGE_EN inserts a register bank after array row
// floor(W/2), raising latency from 1 to 2 cycles while keeping 1 sample/cycle.
module code #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           in_valid,
    output logic [2*W-1:0] p,
    output logic           out_valid
);

    // Last array row handled before the optional mid-array register bank.
    localparam int H = W / 2;

    // One array row: W full-adder ripple chain, returns {carry_out, sum[W-1:0]}.
    function automatic logic [W:0] ripple_row(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] r;
        logic       c;
        r = '0;
        c = 1'b0;
        for (int j = 0; j < W; j++) begin
            r[j] = x[j] ^ y[j] ^ c;
            c    = (x[j] & y[j]) | (c & (x[j] ^ y[j]));
        end
        r[W] = c;
        return r;
    endfunction

    logic [W-1:0]   w_s1_row;
    logic [W:0]     w_s1_rsum;
    logic [H:0]     w_s1_lo;     // settled low product bits p[H:0]
    logic [W-1:0]   w_s1_sum;    // running sum feeding row H+1

    logic [W-1:0]   w_s2_a;
    logic [W-1:0]   w_s2_b;
    logic [H:0]     w_s2_lo;
    logic [W-1:0]   w_s2_sum;
    logic           w_s2_vld;

    logic [W-1:0]   w_s2_row;
    logic [W:0]     w_s2_rsum;
    logic [W-1:0]   w_s2_run;
    logic [2*W-1:0] w_prod;

    logic [2*W-1:0] r_p_p2;
    logic           r_vld_p2;

    // Upper array half: row 0 passes straight through, rows 1..H ripple-add.
    always_comb begin
        w_s1_row   = a & {W{b[0]}};
        w_s1_rsum  = '0;
        w_s1_lo    = '0;
        w_s1_lo[0] = w_s1_row[0];
        w_s1_sum   = {1'b0, w_s1_row[W-1:1]};
        for (int i = 1; i <= H; i++) begin
            w_s1_row    = a & {W{b[i]}};
            w_s1_rsum   = ripple_row(w_s1_row, w_s1_sum);
            w_s1_lo[i]  = w_s1_rsum[0];
            w_s1_sum    = w_s1_rsum[W:1];
        end
    end

`ifdef PIPE_STAGE_EN
    logic [W-1:0] r_a_p1;
    logic [W-1:0] r_b_p1;
    logic [H:0]   r_lo_p1;
    logic [W-1:0] r_sum_p1;
    logic         r_vld_p1;

    // Mid-array bank: only loads on qualified samples so X inputs never enter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_p1   <= '0;
            r_b_p1   <= '0;
            r_lo_p1  <= '0;
            r_sum_p1 <= '0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_a_p1   <= a;
                r_b_p1   <= b;
                r_lo_p1  <= w_s1_lo;
                r_sum_p1 <= w_s1_sum;
            end
        end
    end

    assign w_s2_a   = r_a_p1;
    assign w_s2_b   = r_b_p1;
    assign w_s2_lo  = r_lo_p1;
    assign w_s2_sum = r_sum_p1;
    assign w_s2_vld = r_vld_p1;
`else
    assign w_s2_a   = a;
    assign w_s2_b   = b;
    assign w_s2_lo  = w_s1_lo;
    assign w_s2_sum = w_s1_sum;
    assign w_s2_vld = in_valid;
`endif

    // Lower array half: rows H+1..W-1; final running sum is p[2W-1:W].
    always_comb begin
        w_s2_row  = '0;
        w_s2_rsum = '0;
        w_s2_run  = w_s2_sum;
        w_prod    = '0;
        w_prod[H:0] = w_s2_lo;
        for (int i = H + 1; i < W; i++) begin
            w_s2_row  = w_s2_a & {W{w_s2_b[i]}};
            w_s2_rsum = ripple_row(w_s2_row, w_s2_run);
            w_prod[i] = w_s2_rsum[0];
            w_s2_run  = w_s2_rsum[W:1];
        end
        w_prod[2*W-1:W] = w_s2_run;
    end

    // Output register: product holds when no qualified sample arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_p2   <= '0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p2 <= w_s2_vld;
            if (w_s2_vld) begin
                r_p_p2 <= w_prod;
            end
        end
    end

    assign p         = r_p_p2;
    assign out_valid = r_vld_p2;

endmodule

// File: tb/tb_code.sv
// Directed-vector bench for the Braun array multiplier (W=4).
// Hand-computed products are fed alongside stimulus and delayed by the
// expected latency (1, or 2 when PIPE_STAGE_EN is defined).
module tb_code;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       in_valid;
    logic [7:0] p;
    logic       out_valid;

    int n_cmp;
    int n_err;

    // Expected output-stage state and (pipelined build) mid-stage state.
    logic [7:0] m_p;
    logic       m_v;
    logic [7:0] m1_p;
    logic       m1_v;

    code #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .p         (p),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_p  = 8'h00;
        m_v  = 1'b0;
        m1_p = 8'h00;
        m1_v = 1'b0;
    endtask

    // Drive one sample, advance one edge, update the expected state, check outputs.
    task automatic tick(input logic [3:0] ia, input logic [3:0] ib, input logic iv,
                        input logic [7:0] hp, input string tag);
        @(negedge clk);
        a        = ia;
        b        = ib;
        in_valid = iv;
        @(posedge clk);
`ifdef PIPE_STAGE_EN
        if (m1_v) m_p = m1_p;
        m_v  = m1_v;
        m1_v = iv;
        if (iv) m1_p = hp;
`else
        m_v = iv;
        if (iv) m_p = hp;
`endif
        #1;
        check_eq({tag, ".p"}, {8'h00, p}, {8'h00, m_p});
        check_eq({tag, ".vld"}, {15'h0, out_valid}, {15'h0, m_v});
    endtask

    task automatic flush(input string tag);
`ifdef PIPE_STAGE_EN
        tick(4'h0, 4'h0, 1'b0, 8'h00, tag);
`endif
        tick(4'h0, 4'h0, 1'b0, 8'h00, tag);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();

        // Reset with active-looking inputs, checked before any clock edge.
        rst_n    = 1'b0;
        a        = 4'hF;
        b        = 4'hF;
        in_valid = 1'b1;
        #2;
        check_eq("reset.p", {8'h00, p}, 16'h0000);
        check_eq("reset.vld", {15'h0, out_valid}, 16'h0000);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Directed products.
        tick(4'd4,  4'd1,  1'b1, 8'h04, "4x1");
        tick(4'd4,  4'd10, 1'b1, 8'h28, "4x10");
        tick(4'd5,  4'd10, 1'b1, 8'h32, "5x10");
        tick(4'd10, 4'd10, 1'b1, 8'h64, "10x10");
        // Corners.
        tick(4'd0,  4'd13, 1'b1, 8'h00, "0x13");
        tick(4'd15, 4'd15, 1'b1, 8'hE1, "15x15");
        tick(4'd1,  4'd15, 1'b1, 8'h0F, "1x15");
        tick(4'd8,  4'd8,  1'b1, 8'h40, "8x8");

        // Hold: p keeps 8'h32 while in_valid is low.
        tick(4'd5,  4'd10, 1'b1, 8'h32, "hold_cap");
        tick(4'd3,  4'd3,  1'b0, 8'h09, "hold1");
        tick(4'd3,  4'd3,  1'b0, 8'h09, "hold2");
        tick(4'd3,  4'd3,  1'b0, 8'h09, "hold3");
        tick(4'bxxxx, 4'bxxxx, 1'b0, 8'h00, "xhold");
        check_eq("hold_final.p", {8'h00, p}, 16'h0032);

        // Back-to-back stream.
        tick(4'd3,  4'd3,  1'b1, 8'h09, "s3x3");
        tick(4'd7,  4'd9,  1'b1, 8'h3F, "s7x9");
        tick(4'd12, 4'd11, 1'b1, 8'h84, "s12x11");
        flush("sflush");

        // Reset asserted between edges during a stream.
        tick(4'd2, 4'd3, 1'b1, 8'h06, "pre_rst1");
        tick(4'd4, 4'd4, 1'b1, 8'h10, "pre_rst2");
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("midrst.p", {8'h00, p}, 16'h0000);
        check_eq("midrst.vld", {15'h0, out_valid}, 16'h0000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive sweep.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                logic [3:0] ai;
                logic [3:0] bj;
                logic [7:0] pr;
                ai = i[3:0];
                bj = j[3:0];
                pr = 8'(i * j);
                tick(ai, bj, 1'b1, pr, "sweep");
            end
        end
        flush("sweep_flush");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
